frame_sequencer: RTL and testbench



---
 rtl/frame_sequencer_pkg.sv | 22 ++
 rtl/frame_sequencer_raster_counter.sv | 51 +++++
 rtl/frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: controller state encoding and
// default frame geometry used by the top and the raster counter.
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    STAT_SET,
    STAT_WAIT,
    STAT_OUT,
    DONE
  } state_t;

  localparam int DEF_FRAME_WIDTH  = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int DEF_LOC_SIZE     = 32;
  localparam int DEF_LBL_WIDTH    = 10;
  localparam int DEF_PIXEL_SIZE   = 24;
  localparam int DEF_STAT_LAT     = 2;

endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// Raster position counter: x wraps at the row width and carries into y; y is
// left free-running so positions past the last row stay meaningful.
module raster_counter
  import frame_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH = DEF_FRAME_WIDTH,
  parameter int LOC_SIZE    = DEF_LOC_SIZE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear_i,
  input  logic                advance_i,
  output logic [LOC_SIZE-1:0] x_o,
  output logic [LOC_SIZE-1:0] y_o
);

  localparam logic [LOC_SIZE-1:0] X_LAST = LOC_SIZE'(FRAME_WIDTH - 1);

  logic [LOC_SIZE-1:0] x_q, x_d;
  logic [LOC_SIZE-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + LOC_SIZE'(1);
      end else begin
        x_d = x_q + LOC_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/frame_sequencer.sv
// Frame controller: streams one frame of pixels into the detection pipeline,
// drains it with flush cycles, then reads out per-object statistics records.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int LOC_SIZE     = DEF_LOC_SIZE,
  parameter int LBL_WIDTH    = DEF_LBL_WIDTH,
  parameter int PIXEL_SIZE   = DEF_PIXEL_SIZE,
  parameter int FLUSH_CYCLES = 2 * FRAME_WIDTH + 16,
  parameter int STAT_LAT     = DEF_STAT_LAT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXEL_SIZE-1:0] in_data,
  output logic                  en,
  output logic [LOC_SIZE-1:0]   x,
  output logic [LOC_SIZE-1:0]   y,
  output logic [PIXEL_SIZE-1:0] data,
  output logic [LBL_WIDTH-1:0]  obj_id,
  input  logic [LBL_WIDTH-1:0]  num_labels,
  input  logic [LOC_SIZE-1:0]   obj_area,
  input  logic [LOC_SIZE-1:0]   obj_x,
  input  logic [LOC_SIZE-1:0]   obj_y,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [LBL_WIDTH-1:0]  stat_id,
  output logic [LOC_SIZE-1:0]   stat_area,
  output logic [LOC_SIZE-1:0]   stat_x,
  output logic [LOC_SIZE-1:0]   stat_y,
  output logic                  busy,
  output logic                  done
);

  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam int LAT_W   = $clog2(STAT_LAT + 1);
  localparam logic [LOC_SIZE-1:0] LAST_PIX   = LOC_SIZE'(FRAME_WIDTH * FRAME_HEIGHT - 1);
  localparam logic [FLUSH_W-1:0]  LAST_FLUSH = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [LAT_W-1:0]    LAST_LAT   = LAT_W'(STAT_LAT - 1);

  state_t                state_q, state_d;
  logic [LOC_SIZE-1:0]   pix_cnt_q, pix_cnt_d;
  logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [LBL_WIDTH-1:0]  obj_id_q, obj_id_d;
  logic [LBL_WIDTH-1:0]  num_labels_q, num_labels_d;
  logic [LBL_WIDTH-1:0]  stat_id_q, stat_id_d;
  logic [LOC_SIZE-1:0]   stat_area_q, stat_area_d;
  logic [LOC_SIZE-1:0]   stat_x_q, stat_x_d;
  logic [LOC_SIZE-1:0]   stat_y_q, stat_y_d;
  logic                  raster_clear;

  raster_counter #(
    .FRAME_WIDTH(FRAME_WIDTH),
    .LOC_SIZE   (LOC_SIZE)
  ) u_raster (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (raster_clear),
    .advance_i(en),
    .x_o      (x),
    .y_o      (y)
  );

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    obj_id_d     = obj_id_q;
    num_labels_d = num_labels_q;
    stat_id_d    = stat_id_q;
    stat_area_d  = stat_area_q;
    stat_x_d     = stat_x_q;
    stat_y_d     = stat_y_q;
    in_ready     = 1'b0;
    en           = 1'b0;
    data         = '0;
    raster_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          raster_clear = 1'b1;
          pix_cnt_d    = '0;
          flush_cnt_d  = '0;
          lat_cnt_d    = '0;
          obj_id_d     = '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        en       = in_valid;
        data     = in_data;
        if (in_valid) begin
          pix_cnt_d = pix_cnt_q + LOC_SIZE'(1);
          if (pix_cnt_q == LAST_PIX) begin
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        en          = 1'b1;
        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        if (flush_cnt_q == LAST_FLUSH) begin
          num_labels_d = num_labels;
          if (num_labels == '0) begin
            state_d = DONE;
          end else begin
            obj_id_d = LBL_WIDTH'(1);
            state_d  = STAT_SET;
          end
        end
      end
      STAT_SET: begin
        lat_cnt_d = '0;
        state_d   = STAT_WAIT;
      end
      STAT_WAIT: begin
        // The stats block answers STAT_LAT cycles after obj_id moved (entry to STAT_SET).
        if (lat_cnt_q == LAST_LAT) begin
          stat_id_d   = obj_id_q;
          stat_area_d = obj_area;
          stat_x_d    = obj_x;
          stat_y_d    = obj_y;
          state_d     = STAT_OUT;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      STAT_OUT: begin
        if (stat_ready) begin
          if (obj_id_q == num_labels_q) begin
            state_d = DONE;
          end else begin
            obj_id_d = obj_id_q + LBL_WIDTH'(1);
            state_d  = STAT_SET;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      lat_cnt_q    <= '0;
      obj_id_q     <= '0;
      num_labels_q <= '0;
      stat_id_q    <= '0;
      stat_area_q  <= '0;
      stat_x_q     <= '0;
      stat_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      obj_id_q     <= obj_id_d;
      num_labels_q <= num_labels_d;
      stat_id_q    <= stat_id_d;
      stat_area_q  <= stat_area_d;
      stat_x_q     <= stat_x_d;
      stat_y_q     <= stat_y_d;
    end
  end

  assign obj_id     = obj_id_q;
  assign stat_valid = (state_q == STAT_OUT);
  assign stat_id    = stat_id_q;
  assign stat_area  = stat_area_q;
  assign stat_x     = stat_x_q;
  assign stat_y     = stat_y_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x3 frame with a stub connected-
// components stats block whose answers lag obj_id by two cycles.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        inValid;
  logic        inReady;
  logic [23:0] inData;
  logic        en;
  logic [31:0] x, y;
  logic [23:0] data;
  logic [9:0]  objId;
  logic [9:0]  numLabels;
  logic [31:0] objArea, objX, objY;
  logic        statValid;
  logic        statReady;
  logic [9:0]  statId;
  logic [31:0] statArea, statX, statY;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_sequencer #(
    .FRAME_WIDTH (4),
    .FRAME_HEIGHT(3),
    .LOC_SIZE    (32),
    .LBL_WIDTH   (10),
    .PIXEL_SIZE  (24),
    .FLUSH_CYCLES(10),
    .STAT_LAT    (2)
  ) dut (
    .clk       (clk),
    .reset_n   (resetN),
    .start     (start),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .en        (en),
    .x         (x),
    .y         (y),
    .data      (data),
    .obj_id    (objId),
    .num_labels(numLabels),
    .obj_area  (objArea),
    .obj_x     (objX),
    .obj_y     (objY),
    .stat_valid(statValid),
    .stat_ready(statReady),
    .stat_id   (statId),
    .stat_area (statArea),
    .stat_x    (statX),
    .stat_y    (statY),
    .busy      (busy),
    .done      (done)
  );

  // Stub stats block: answers for obj_id appear two cycles after it changes.
  logic [9:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= objId;
    pipe1 <= pipe0;
  end
  assign objArea = 32'(pipe1) * 32'd10;
  assign objX    = 32'(pipe1) * 32'd10 + 32'd1;
  assign objY    = 32'(pipe1) * 32'd10 + 32'd2;

  typedef struct {
    logic        inValid;
    logic [23:0] inData;
    logic        expEn;
    logic        expRdy;
    logic [31:0] expX;
    logic [31:0] expY;
    logic [23:0] expData;
  } vec_t;

  typedef struct {
    logic        sv;
    logic [9:0]  id;
    logic [31:0] area;
    logic        done;
    logic        busy;
    logic [9:0]  objId;
  } sched_t;

  vec_t   frameVecs[22];
  sched_t readSched[14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expVal);
    checks++;
    if (act !== expVal) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expVal);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, 64'(inReady), 0);
    checkOutput({tag, " en"}, 64'(en), 0);
    checkOutput({tag, " x"}, 64'(x), 0);
    checkOutput({tag, " y"}, 64'(y), 0);
    checkOutput({tag, " data"}, 64'(data), 0);
    checkOutput({tag, " obj_id"}, 64'(objId), 0);
    checkOutput({tag, " stat_valid"}, 64'(statValid), 0);
    checkOutput({tag, " stat_id"}, 64'(statId), 0);
    checkOutput({tag, " stat_area"}, 64'(statArea), 0);
    checkOutput({tag, " stat_x"}, 64'(statX), 0);
    checkOutput({tag, " stat_y"}, 64'(statY), 0);
    checkOutput({tag, " busy"}, 64'(busy), 0);
    checkOutput({tag, " done"}, 64'(done), 0);
  endtask

  task automatic applyStimulus(input string tag);
    for (int i = 0; i < 22; i++) begin
      inValid = frameVecs[i].inValid;
      inData  = frameVecs[i].inData;
      @(negedge clk);
      checkOutput($sformatf("%s en[%0d]", tag, i), 64'(en), 64'(frameVecs[i].expEn));
      checkOutput($sformatf("%s rdy[%0d]", tag, i), 64'(inReady), 64'(frameVecs[i].expRdy));
      checkOutput($sformatf("%s x[%0d]", tag, i), 64'(x), 64'(frameVecs[i].expX));
      checkOutput($sformatf("%s y[%0d]", tag, i), 64'(y), 64'(frameVecs[i].expY));
      checkOutput($sformatf("%s data[%0d]", tag, i), 64'(data), 64'(frameVecs[i].expData));
      tick();
    end
    inValid = 1'b0;
    inData  = '0;
  endtask

  initial begin
    int accepted;
    int doneCount;
    int holdCnt;
    int expNext;
    logic v;

    frameVecs[0]  = '{1'b1, 24'h000100, 1'b1, 1'b1, 32'd0, 32'd0, 24'h000100};
    frameVecs[1]  = '{1'b1, 24'h000101, 1'b1, 1'b1, 32'd1, 32'd0, 24'h000101};
    frameVecs[2]  = '{1'b1, 24'h000102, 1'b1, 1'b1, 32'd2, 32'd0, 24'h000102};
    frameVecs[3]  = '{1'b1, 24'h000103, 1'b1, 1'b1, 32'd3, 32'd0, 24'h000103};
    frameVecs[4]  = '{1'b1, 24'h000104, 1'b1, 1'b1, 32'd0, 32'd1, 24'h000104};
    frameVecs[5]  = '{1'b1, 24'h000105, 1'b1, 1'b1, 32'd1, 32'd1, 24'h000105};
    frameVecs[6]  = '{1'b1, 24'h000106, 1'b1, 1'b1, 32'd2, 32'd1, 24'h000106};
    frameVecs[7]  = '{1'b1, 24'h000107, 1'b1, 1'b1, 32'd3, 32'd1, 24'h000107};
    frameVecs[8]  = '{1'b1, 24'h000108, 1'b1, 1'b1, 32'd0, 32'd2, 24'h000108};
    frameVecs[9]  = '{1'b1, 24'h000109, 1'b1, 1'b1, 32'd1, 32'd2, 24'h000109};
    frameVecs[10] = '{1'b1, 24'h00010A, 1'b1, 1'b1, 32'd2, 32'd2, 24'h00010A};
    frameVecs[11] = '{1'b1, 24'h00010B, 1'b1, 1'b1, 32'd3, 32'd2, 24'h00010B};
    frameVecs[12] = '{1'b1, 24'hFFFFFF, 1'b1, 1'b0, 32'd0, 32'd3, 24'h000000};
    frameVecs[13] = '{1'b1, 24'hFFFFFF, 1'b1, 1'b0, 32'd1, 32'd3, 24'h000000};
    frameVecs[14] = '{1'b1, 24'hFFFFFF, 1'b1, 1'b0, 32'd2, 32'd3, 24'h000000};
    frameVecs[15] = '{1'b1, 24'hFFFFFF, 1'b1, 1'b0, 32'd3, 32'd3, 24'h000000};
    frameVecs[16] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'd0, 32'd4, 24'h000000};
    frameVecs[17] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'd1, 32'd4, 24'h000000};
    frameVecs[18] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'd2, 32'd4, 24'h000000};
    frameVecs[19] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'd3, 32'd4, 24'h000000};
    frameVecs[20] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'd0, 32'd5, 24'h000000};
    frameVecs[21] = '{1'b0, 24'h000000, 1'b1, 1'b0, 32'd1, 32'd5, 24'h000000};

    readSched[0]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd1};
    readSched[1]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd1};
    readSched[2]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd1};
    readSched[3]  = '{1'b1, 10'd1, 32'd10, 1'b0, 1'b1, 10'd1};
    readSched[4]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd2};
    readSched[5]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd2};
    readSched[6]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd2};
    readSched[7]  = '{1'b1, 10'd2, 32'd20, 1'b0, 1'b1, 10'd2};
    readSched[8]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd3};
    readSched[9]  = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd3};
    readSched[10] = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b1, 10'd3};
    readSched[11] = '{1'b1, 10'd3, 32'd30, 1'b0, 1'b1, 10'd3};
    readSched[12] = '{1'b0, 10'd0, 32'd0,  1'b1, 1'b1, 10'd3};
    readSched[13] = '{1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 10'd3};

    resetN    = 1'b0;
    start     = 1'b0;
    inValid   = 1'b0;
    inData    = '0;
    numLabels = 10'd3;
    statReady = 1'b1;

    // Reset values, then a full frame with continuous pixels and a 3-object readout.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    tick();
    resetN = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus("frame1");
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checkOutput($sformatf("read stat_valid[%0d]", k), 64'(statValid), 64'(readSched[k].sv));
      checkOutput($sformatf("read done[%0d]", k), 64'(done), 64'(readSched[k].done));
      checkOutput($sformatf("read busy[%0d]", k), 64'(busy), 64'(readSched[k].busy));
      checkOutput($sformatf("read obj_id[%0d]", k), 64'(objId), 64'(readSched[k].objId));
      if (readSched[k].sv) begin
        checkOutput($sformatf("read stat_id[%0d]", k), 64'(statId), 64'(readSched[k].id));
        checkOutput($sformatf("read stat_area[%0d]", k), 64'(statArea), 64'(readSched[k].area));
        checkOutput($sformatf("read stat_x[%0d]", k), 64'(statX), 64'(readSched[k].area + 1));
        checkOutput($sformatf("read stat_y[%0d]", k), 64'(statY), 64'(readSched[k].area + 2));
      end
      tick();
    end

    // Random valid gaps, then a frame with no objects.
    numLabels = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    accepted = 0;
    for (int c = 0; c < 200 && accepted < 12; c++) begin
      v = 1'($urandom_range(0, 1));
      inValid = v;
      inData  = 24'hA00 + 24'(c);
      @(negedge clk);
      checkOutput($sformatf("gap en[%0d]", c), 64'(en), 64'(v));
      checkOutput($sformatf("gap rdy[%0d]", c), 64'(inReady), 1);
      checkOutput($sformatf("gap x[%0d]", c), 64'(x), 64'(accepted % 4));
      checkOutput($sformatf("gap y[%0d]", c), 64'(y), 64'(accepted / 4));
      if (v) begin
        checkOutput($sformatf("gap data[%0d]", c), 64'(data), 64'(inData));
        accepted++;
      end
      tick();
    end
    inValid = 1'b0;
    checkOutput("gap accepted", 64'(accepted), 12);
    for (int f = 0; f < 10; f++) begin
      @(negedge clk);
      checkOutput($sformatf("gap flush en[%0d]", f), 64'(en), 1);
      checkOutput($sformatf("gap flush x[%0d]", f), 64'(x), 64'(f % 4));
      checkOutput($sformatf("gap flush y[%0d]", f), 64'(y), 64'(3 + f / 4));
      checkOutput($sformatf("gap flush done[%0d]", f), 64'(done), 0);
      tick();
    end
    @(negedge clk);
    checkOutput("nolabel done", 64'(done), 1);
    checkOutput("nolabel stat_valid", 64'(statValid), 0);
    checkOutput("nolabel en", 64'(en), 0);
    tick();
    @(negedge clk);
    checkOutput("nolabel busy", 64'(busy), 0);
    checkOutput("nolabel done off", 64'(done), 0);
    tick();

    // Back-pressure on record 2: held stable for five cycles.
    numLabels = 10'd3;
    statReady = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus("frame3");
    doneCount = 0;
    holdCnt   = 0;
    expNext   = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (statValid) begin
        if (statId == 10'd2 && holdCnt < 5) begin
          checkOutput($sformatf("hold id[%0d]", holdCnt), 64'(statId), 2);
          checkOutput($sformatf("hold area[%0d]", holdCnt), 64'(statArea), 20);
          checkOutput($sformatf("hold obj_id[%0d]", holdCnt), 64'(objId), 2);
          statReady = 1'b0;
          holdCnt++;
        end else begin
          statReady = 1'b1;
          checkOutput($sformatf("bp rec id[%0d]", expNext), 64'(statId), 64'(expNext));
          checkOutput($sformatf("bp rec area[%0d]", expNext), 64'(statArea), 64'(10 * expNext));
          expNext++;
        end
      end
      if (done) doneCount++;
      tick();
    end
    statReady = 1'b1;
    checkOutput("bp hold cycles", 64'(holdCnt), 5);
    checkOutput("bp records", 64'(expNext - 1), 3);
    checkOutput("bp done pulses", 64'(doneCount), 1);

    // Ignored start during STREAM, then async reset at pixel 6 and a clean rerun.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      inValid = 1'b1;
      inData  = 24'h300 + 24'(p);
      start   = (p == 3);
      @(negedge clk);
      checkOutput($sformatf("pre-reset x[%0d]", p), 64'(x), 64'(p % 4));
      checkOutput($sformatf("pre-reset y[%0d]", p), 64'(y), 64'(p / 4));
      tick();
    end
    start = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tick();
    resetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("idle en[%0d]", c), 64'(en), 0);
      checkOutput($sformatf("idle rdy[%0d]", c), 64'(inReady), 0);
      checkOutput($sformatf("idle busy[%0d]", c), 64'(busy), 0);
      tick();
    end
    inValid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus("rerun");
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) doneCount++;
      tick();
    end
    checkOutput("rerun done pulses", 64'(doneCount), 1);
    @(negedge clk);
    checkOutput("rerun busy", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
